// File: rtl/micro_bus_pkg.sv
// Shared types and register map for the micro bus responder.
package micro_bus_pkg;

   typedef enum logic {StIdle, StRdData} state_t;

   localparam logic [2:0] REG_PEND   = 3'd0;
   localparam logic [2:0] REG_MASK   = 3'd1;
   localparam logic [2:0] REG_TLOAD  = 3'd2;
   localparam logic [2:0] REG_TCOUNT = 3'd3;
   localparam logic [2:0] REG_TCTRL  = 3'd4;
   localparam logic [2:0] REG_PSET   = 3'd5;

   localparam int unsigned TCTRL_EN = 0;
   localparam int unsigned TCTRL_AR = 1;

endpackage

// File: rtl/micro_ram.sv
// Single-port synchronous word RAM with a registered read port.
module micro_ram #(
   parameter int unsigned AW = 10,
   parameter int unsigned DW = 18
) (
   input  logic          clock,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(2**AW)-1];

   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/micro_bus_responder.sv
// Bus target for the micro core: word RAM, interrupt/timer register bank, one-wait-state reads.
module micro_bus_responder
   import micro_bus_pkg::*;
#(
   parameter int unsigned WIDTHA      = 16,
   parameter int unsigned WIDTHD      = 18,
   parameter int unsigned RAM_AW      = 10,
   parameter int unsigned PERIPH_BASE = 'hFF00
) (
   input  logic              clock,
   input  logic              clock_areset_n,
   input  logic [WIDTHA-1:0] address,
   input  logic [WIDTHD-1:0] writedata,
   output logic [WIDTHD-1:0] readdata,
   input  logic              read,
   input  logic              write,
   output logic              waitrequest,
   input  logic [WIDTHD-2:0] ext_irq,
   output logic [WIDTHD-1:0] irq
);

   localparam logic [WIDTHA-1:0] PBASE = WIDTHA'(PERIPH_BASE);

   state_t state_q, state_d;
   logic rd_launch, ram_sel, periph_sel, reg_we, sel_ram_q;
   logic [2:0] reg_idx;
   logic [WIDTHD-1:0] ram_rdata, reg_rdata, reg_rdata_q, hold_q;
   logic [WIDTHD-1:0] pend_q, pend_d, mask_q, mask_d, tload_q, tload_d, tcount_q, tcount_d;
   logic [WIDTHD-1:0] hw_set, w1c, w1s, irq_q;
   logic [1:0] tctrl_q, tctrl_d;
   logic [WIDTHD-2:0] ext_s_q, ext_d_q, ext_edge;

   assign ram_sel    = (address >> RAM_AW) == '0;
   assign periph_sel = address[WIDTHA-1:3] == PBASE[WIDTHA-1:3];
   assign reg_idx    = address[2:0];
   assign reg_we     = write & periph_sel;
   assign ext_edge   = ext_s_q & ~ext_d_q;
   assign irq        = irq_q;

   // A simultaneous write wins over a read, so it never launches a read or stalls.
   always_comb begin
      state_d     = state_q;
      waitrequest = 1'b0;
      rd_launch   = 1'b0;
      case (state_q)
         StIdle: begin
            if (read && !write) begin
               waitrequest = 1'b1;
               rd_launch   = 1'b1;
               state_d     = StRdData;
            end
         end
         StRdData: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   micro_ram #(
      .AW (RAM_AW),
      .DW (WIDTHD)
   ) u_ram (
      .clock (clock),
      .we    (write & ram_sel),
      .re    (rd_launch & ram_sel),
      .addr  (address[RAM_AW-1:0]),
      .wdata (writedata),
      .rdata (ram_rdata)
   );

   always_comb begin
      reg_rdata = '0;
      case (reg_idx)
         REG_PEND:   reg_rdata = pend_q;
         REG_MASK:   reg_rdata = mask_q;
         REG_TLOAD:  reg_rdata = tload_q;
         REG_TCOUNT: reg_rdata = tcount_q;
         REG_TCTRL:  reg_rdata = WIDTHD'(tctrl_q);
         default:    reg_rdata = '0;
      endcase
   end

   assign readdata = (state_q == StRdData) ? (sel_ram_q ? ram_rdata : reg_rdata_q) : hold_q;

   always_comb begin
      tcount_d = tcount_q;
      tload_d  = tload_q;
      tctrl_d  = tctrl_q;
      mask_d   = mask_q;
      w1c      = '0;
      w1s      = '0;
      hw_set   = {ext_edge, 1'b0};
      if (tctrl_q[TCTRL_EN]) begin
         if (tcount_q == '0) begin
            hw_set[0] = 1'b1;
            tcount_d  = tload_q;
            if (!tctrl_q[TCTRL_AR]) tctrl_d[TCTRL_EN] = 1'b0;
         end else begin
            tcount_d = tcount_q - WIDTHD'(1);
         end
      end
      if (reg_we) begin
         case (reg_idx)
            REG_PEND:  w1c = writedata;
            REG_MASK:  mask_d = writedata;
            REG_TLOAD: begin
               tload_d  = writedata;
               tcount_d = writedata;
            end
            REG_TCTRL: tctrl_d = writedata[1:0];
            REG_PSET:  w1s = writedata;
            default:   ;
         endcase
      end
      // Hardware sets are ORed in after the clear so an interrupt is never lost.
      pend_d = (pend_q & ~w1c) | w1s | hw_set;
   end

   always_ff @(posedge clock or negedge clock_areset_n) begin
      if (!clock_areset_n) begin
         state_q     <= StIdle;
         sel_ram_q   <= 1'b0;
         reg_rdata_q <= '0;
         hold_q      <= '0;
         pend_q      <= '0;
         mask_q      <= '0;
         tload_q     <= '0;
         tcount_q    <= '0;
         tctrl_q     <= '0;
         ext_s_q     <= '0;
         ext_d_q     <= '0;
         irq_q       <= '0;
      end else begin
         state_q <= state_d;
         if (rd_launch) begin
            sel_ram_q   <= ram_sel;
            reg_rdata_q <= periph_sel ? reg_rdata : '0;
         end
         if (state_q == StRdData) hold_q <= readdata;
         pend_q   <= pend_d;
         mask_q   <= mask_d;
         tload_q  <= tload_d;
         tcount_q <= tcount_d;
         tctrl_q  <= tctrl_d;
         ext_s_q  <= ext_irq;
         ext_d_q  <= ext_s_q;
         irq_q    <= pend_q & mask_q;
      end
   end

endmodule

// File: tb/tb_micro_bus_responder.sv
// Scoreboard bench for micro_bus_responder: directed scenarios plus a randomized bus phase.
module tb_micro_bus_responder;

   logic        clock = 1'b0;
   logic        clock_areset_n;
   logic [15:0] address;
   logic [17:0] writedata, readdata;
   logic        read, write, waitrequest;
   logic [16:0] ext_irq;
   logic [17:0] irq;

   int n_checks = 0;
   int n_errors = 0;
   logic [17:0] exp_q[$];
   int unsigned cyc = 0;

   // reference model of architectural state
   logic [17:0] ram_m [0:1023];
   logic [17:0] pend_m, mask_m, tload_m;
   logic [1:0]  tctrl_m;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   micro_bus_responder #(
      .WIDTHA      (16),
      .WIDTHD      (18),
      .RAM_AW      (10),
      .PERIPH_BASE ('hFF00)
   ) dut (
      .clock          (clock),
      .clock_areset_n (clock_areset_n),
      .address        (address),
      .writedata      (writedata),
      .readdata       (readdata),
      .read           (read),
      .write          (write),
      .waitrequest    (waitrequest),
      .ext_irq        (ext_irq),
      .irq            (irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, expv);
      end
   endtask

   // monitor: every completed read pops one expected value
   always @(negedge clock) begin
      if (clock_areset_n && read && !write && !waitrequest) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rd_unexpected: got 'h%0h with no read outstanding", readdata);
         end else begin
            check("readdata", 32'(readdata), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [17:0] d);
      address = a; writedata = d; write = 1'b1;
      #1;
      check("wr_wait", 32'(waitrequest), 0);
      @(posedge clock);
      #1;
      write = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, input logic [17:0] e);
      int n;
      address = a; read = 1'b1;
      exp_q.push_back(e);
      #1;
      check("rd_wait0", 32'(waitrequest), 1);
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (waitrequest && n < 8);
      check("rd_latency", 32'(n), 1);
      if (waitrequest) void'(exp_q.pop_back());
      @(posedge clock);
      #1;
      read = 1'b0;
   endtask

   task automatic do_reset();
      read = 1'b0; write = 1'b0; ext_irq = '0; address = '0; writedata = '0;
      clock_areset_n = 1'b0;
      tick(2);
      clock_areset_n = 1'b1;
      tick(1);
      pend_m = '0; mask_m = '0; tload_m = '0; tctrl_m = '0;
   endtask

   function automatic logic [17:0] model_read(input int k);
      case (k)
         0:       return pend_m;
         1:       return mask_m;
         2, 3:    return tload_m;   // timer never enabled in the random phase
         4:       return {16'd0, tctrl_m};
         default: return '0;
      endcase
   endfunction

   task automatic model_write(input int k, input logic [17:0] d);
      case (k)
         0:       pend_m = pend_m & ~d;
         1:       mask_m = d;
         2:       tload_m = d;
         4:       tctrl_m = d[1:0];
         5:       pend_m = pend_m | d;
         default: ;
      endcase
   endtask

   function automatic logic [15:0] unmapped_addr();
      case ($urandom_range(0, 4))
         0:       return 16'h0400;
         1:       return 16'h8000;
         2:       return 16'hFEFF;
         3:       return 16'(16'hFF08 + $urandom_range(0, 247));
         default: return 16'(16'h0400 + $urandom_range(0, 'hFAFF));
      endcase
   endfunction

   function automatic logic [15:0] ram_pick(input int i);
      return (i == 15) ? 16'd1023 : 16'(i * 3);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned ew;
      int n, op, k;
      logic [15:0] a;
      logic [17:0] d;

      clock_areset_n = 1'b0;
      read = 1'b0; write = 1'b0; ext_irq = '0; address = '0; writedata = '0;
      #3;
      check("rst_readdata", 32'(readdata), 0);
      check("rst_irq", 32'(irq), 0);
      check("rst_wait", 32'(waitrequest), 0);
      do_reset();

      // RAM write then read; read & write together acts as a write
      bus_write(16'd5, 18'h2A);
      bus_read(16'd5, 18'h2A);
      check("rd_hold", 32'(readdata), 'h2A);
      address = 16'd3; writedata = 18'h1111; read = 1'b1; write = 1'b1;
      #1;
      check("rdwr_wait", 32'(waitrequest), 0);
      @(posedge clock);
      #1;
      read = 1'b0; write = 1'b0;
      bus_read(16'd3, 18'h1111);

      // unmapped accesses
      bus_write(16'd0, 18'h155);
      bus_read(16'h8000, 18'h0);
      bus_write(16'h8000, 18'h3FFFF);
      bus_read(16'h8000, 18'h0);
      bus_read(16'd0, 18'h155);
      bus_read(16'hFF00, 18'h0);

      // software set
      bus_write(16'hFF05, 18'h30);
      bus_read(16'hFF00, 18'h30);
      bus_read(16'hFF05, 18'h0);

      // reset while a read is in its data cycle
      bus_write(16'hFF01, 18'h30);
      tick(1);
      check("irq_pre_rst", 32'(irq), 'h30);
      bus_write(16'd7, 18'h1234);
      address = 16'd7; read = 1'b1;
      tick(1);
      clock_areset_n = 1'b0;
      read = 1'b0;
      #1;
      check("midrd_readdata", 32'(readdata), 0);
      check("midrd_irq", 32'(irq), 0);
      read = 1'b1;
      #1;
      check("midrd_idle", 32'(waitrequest), 1);
      read = 1'b0;
      tick(1);
      clock_areset_n = 1'b1;
      tick(1);
      bus_read(16'd7, 18'h1234);

      // timer: TLOAD=3 autoreload expires every 4 clocks; W1C on expiry loses to the set
      do_reset();
      bus_write(16'hFF01, 18'h1);
      bus_write(16'hFF02, 18'h3);
      bus_write(16'hFF04, 18'h3);
      ew = cyc;
      n = 0;
      while (!irq[0] && n < 20) begin
         tick(1);
         n++;
      end
      check("timer_first_irq", cyc - ew, 5);
      while (cyc < ew + 8) tick(1);
      bus_write(16'hFF00, 18'h1);
      tick(1);
      check("timer_w1c_irq", 32'(irq[0]), 0);
      while (cyc < ew + 11) tick(1);
      bus_write(16'hFF00, 18'h1);
      bus_read(16'hFF00, 18'h1);
      bus_write(16'hFF04, 18'h0);

      // external irq edge detect
      do_reset();
      bus_write(16'hFF01, 18'h2);
      ext_irq[0] = 1'b1;
      tick(5);
      check("ext_irq", 32'(irq), 'h2);
      bus_read(16'hFF00, 18'h2);
      bus_write(16'hFF00, 18'h2);
      tick(5);
      check("ext_clear", 32'(irq), 0);
      bus_read(16'hFF00, 18'h0);
      ext_irq = '0;

      // randomized phase against the model
      do_reset();
      for (int i = 0; i < 16; i++) begin
         a = ram_pick(i);
         d = 18'($urandom);
         bus_write(a, d);
         ram_m[a[9:0]] = d;
      end
      for (int it = 0; it < 150; it++) begin
         op = int'($urandom_range(0, 5));
         a  = ram_pick(int'($urandom_range(0, 15)));
         k  = int'($urandom_range(0, 7));
         d  = 18'($urandom);
         case (op)
            0: begin
               bus_write(a, d);
               ram_m[a[9:0]] = d;
            end
            1: bus_read(a, ram_m[a[9:0]]);
            2: begin
               if (k == 4) d[0] = 1'b0;
               bus_write(16'(16'hFF00 + k), d);
               model_write(k, d);
            end
            3: bus_read(16'(16'hFF00 + k), model_read(k));
            4: bus_write(unmapped_addr(), d);
            default: bus_read(unmapped_addr(), 18'h0);
         endcase
         tick(1);
         check("irq", 32'(irq), 32'(pend_m & mask_m));
      end

      tick(2);
      check("queue_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
